icache_ctrl: RTL and testbench

- Direct-mapped, read-only instruction cache controller between the program counter register and instruction memory.
- Consumes the current PC and returns the 32-bit instruction on a hit.
- On a miss it refills one 256-bit line from memory over a req/ack handshake and asserts stall_o; stall_o drives the PC's cache-stall input, so the PC holds until the line arrives.

---
 rtl/icache_ctrl.sv | 113 +++++++++++
 tb/tb_icache_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller.
// On a hit the instruction is returned combinationally. On a miss the
// controller stalls the fetch stage and refills one 256-bit line from
// memory over a req/ack handshake.
module icache_ctrl #(
  parameter int unsigned NUM_LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         fetch_en_i,
  input  logic [31:0]  pc_i,
  input  logic         inv_i,
  output logic [31:0]  instr_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic [31:0]  mem_addr_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i
);

  localparam int unsigned IDX  = $clog2(NUM_LINES);
  localparam int unsigned TAGW = 27 - IDX;

  typedef enum logic [1:0] {StIdle, StMiss, StFill} state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAGW-1:0]      tag_q  [NUM_LINES];
  logic [255:0]         data_q [NUM_LINES];
  logic [26:0]          miss_line_q;  // miss_addr[31:5]; low bits are always zero
  logic                 inv_pend_q;

  logic [2:0]      offset;
  logic [IDX-1:0]  index;
  logic [TAGW-1:0] tag;
  logic [IDX-1:0]  fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic [255:0]    line;
  logic            hit;
  logic            miss;
  logic            fill_we;
  logic            unused_pc;

  assign offset    = pc_i[4:2];
  assign index     = pc_i[IDX+4:5];
  assign tag       = pc_i[31:IDX+5];
  assign fill_idx  = miss_line_q[IDX-1:0];
  assign fill_tag  = miss_line_q[26:IDX];
  assign line      = data_q[index];
  assign unused_pc = ^pc_i[1:0];

  // Lookup, stall and memory request outputs
  always_comb begin
    hit        = (state_q == StIdle) && fetch_en_i && valid_q[index] && (tag_q[index] == tag);
    miss       = (state_q == StIdle) && fetch_en_i && !hit;
    instr_o    = hit ? line[{offset, 5'b0} +: 32] : 32'h0;
    stall_o    = (state_q != StIdle) || miss;
    mem_req_o  = (state_q == StMiss);
    mem_addr_o = mem_req_o ? {miss_line_q, 5'b0} : 32'h0;
    fill_we    = (state_q == StMiss) && mem_ack_i;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (miss) state_d = StMiss;
      StMiss:  if (mem_ack_i) state_d = StFill;
      StFill:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, valid bits, miss address and deferred invalidate
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      miss_line_q <= '0;
      inv_pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          // Invalidate and miss capture may coincide; the refill still lands valid.
          if (inv_i) valid_q <= '0;
          if (miss) miss_line_q <= pc_i[31:5];
        end
        StMiss: begin
          if (inv_i) inv_pend_q <= 1'b1;
          if (mem_ack_i) valid_q[fill_idx] <= 1'b1;
        end
        StFill: begin
          // Deferred invalidate lands on IDLE entry and also kills the fresh line.
          if (inv_i || inv_pend_q) begin
            valid_q    <= '0;
            inv_pend_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays; deliberately not reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && fill_we) begin
      data_q[fill_idx] <= mem_data_i;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: randomized fetch/invalidate/reset traffic against a
// line-residency model, with an expectation queue drained by a monitor and a
// memory responder that checks refill addresses.
module tb_icache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         fetch_en_i;
  logic [31:0]  pc_i;
  logic         inv_i;
  logic [31:0]  instr_o;
  logic         stall_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;

  logic         resp_ack;
  logic [255:0] resp_data;
  logic         late_ack;
  logic [255:0] late_data;

  assign mem_ack_i  = resp_ack | late_ack;
  assign mem_data_i = late_ack ? late_data : resp_data;

  icache_ctrl #(.NUM_LINES(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .fetch_en_i (fetch_en_i),
    .pc_i       (pc_i),
    .inv_i      (inv_i),
    .instr_o    (instr_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_addr_q[$];
  int          req_lat_q[$];

  // Model: which memory line (pc[31:5]) each index holds, if any.
  bit          res_v[32];
  logic [26:0] res_line[32];

  int n_vec = 0;
  int n_err = 0;
  bit done;
  int stall_cnt = 0;
  int req_cnt = 0;
  logic [31:0] cur_addr;
  int cur_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2001_0001 + {a[31:2], 2'b00};
  endfunction

  function automatic logic [255:0] line_data(input logic [31:0] base);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = mem_word(base + 32'(4 * k));
    return d;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) res_v[i] = 1'b0;
  endtask

  // Monitor: completes a fetch when the DUT stops stalling; checks idle outputs.
  always @(negedge clk_i) begin
    if (rst_i) begin
      stall_cnt = 0;
    end else if (fetch_en_i) begin
      if (stall_o) begin
        stall_cnt++;
      end else begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("instr", instr_o, e.instr);
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
        end
        stall_cnt = 0;
        done = 1'b1;
      end
    end else begin
      chk("idle_stall", {31'b0, stall_o}, 32'd0);
      chk("idle_req", {31'b0, mem_req_o}, 32'd0);
      chk("idle_instr", instr_o, 32'h0);
    end
  end

  // Memory responder: acks in the lat-th cycle of a request, checks the address.
  always @(negedge clk_i) begin
    if (mem_req_o && !rst_i) begin
      if (req_cnt == 0) begin
        if (req_addr_q.size() == 0) begin
          chk("unexpected_request", mem_addr_o, 32'hFFFF_FFFF);
          cur_addr = mem_addr_o;
          cur_lat  = 1;
        end else begin
          cur_addr = req_addr_q.pop_front();
          cur_lat  = req_lat_q.pop_front();
        end
      end
      chk("mem_addr", mem_addr_o, cur_addr);
      req_cnt++;
      if (req_cnt == cur_lat) begin
        resp_ack  = 1'b1;
        resp_data = line_data(cur_addr);
      end else begin
        resp_ack  = 1'b0;
        resp_data = rand_line();
      end
    end else begin
      req_cnt   = 0;
      resp_ack  = 1'b0;
      resp_data = rand_line();
    end
  end

  task automatic finish_fatal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "fetch did not complete");
  endtask

  // mode 0: plain fetch; 1: inv_i alongside the lookup; 2: inv_i during the miss.
  task automatic do_fetch(input logic [31:0] pc, input int mode, input int lat_force);
    logic [26:0] ln;
    int          idx;
    bit          hit;
    int          lat;
    int          st;
    exp_t        e;
    ln  = pc[31:5];
    idx = int'(pc[9:5]);
    hit = res_v[idx] && (res_line[idx] == ln);
    lat = (lat_force > 0) ? lat_force : int'($urandom_range(1, 4));
    st  = 0;
    if (!hit) begin
      req_addr_q.push_back({ln, 5'b0});
      req_lat_q.push_back(lat);
      st = lat + 2;
    end
    if (mode == 1) model_clear();
    if (mode == 2 && !hit) begin
      // First refill is invalidated on IDLE entry; the lookup then re-misses.
      lat = int'($urandom_range(1, 4));
      req_addr_q.push_back({ln, 5'b0});
      req_lat_q.push_back(lat);
      st += lat + 2;
      model_clear();
    end
    if (!hit) begin
      res_v[idx]    = 1'b1;
      res_line[idx] = ln;
    end
    e.instr = mem_word(pc);
    e.stall = st;
    exp_q.push_back(e);

    done       = 1'b0;
    fetch_en_i = 1'b1;
    pc_i       = pc;
    inv_i      = (mode == 1);
    @(posedge clk_i); #1;
    inv_i = 1'b0;
    if (mode == 2 && !hit) begin
      inv_i = 1'b1;
      @(posedge clk_i); #1;
      inv_i = 1'b0;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk_i); #1;
    end
    if (!done) begin
      n_err++;
      $display("FAIL fetch_timeout: pc %h still stalled, expected completion", pc);
      finish_fatal();
    end
  endtask

  // One cycle with fetch disabled; optional invalidate and stray ack.
  task automatic do_idle(input logic [31:0] pc, input bit inv, input bit stray);
    fetch_en_i = 1'b0;
    pc_i       = pc;
    inv_i      = inv;
    late_ack   = stray;
    late_data  = rand_line();
    if (inv) model_clear();
    @(posedge clk_i); #1;
    inv_i    = 1'b0;
    late_ack = 1'b0;
  endtask

  // Reset while a refill request is outstanding, then a late ack.
  task automatic do_reset_mid(input logic [31:0] pc);
    do_idle(pc, 1'b1, 1'b0);
    req_addr_q.push_back({pc[31:5], 5'b0});
    req_lat_q.push_back(1000);
    fetch_en_i = 1'b1;
    pc_i       = pc;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("req_before_reset", {31'b0, mem_req_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_i      = 1'b1;
    fetch_en_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_clear();
    @(negedge clk_i);
    chk("req_after_reset", {31'b0, mem_req_o}, 32'd0);
    chk("addr_after_reset", mem_addr_o, 32'h0);
    @(posedge clk_i); #1;
    do_idle(pc, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) |
        ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    return p;
  endfunction

  initial begin
    rst_i      = 1'b1;
    fetch_en_i = 1'b0;
    pc_i       = 32'h0;
    inv_i      = 1'b0;
    late_ack   = 1'b0;
    late_data  = '0;
    done       = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_addr", mem_addr_o, 32'h0);
    @(posedge clk_i); #1;

    // Cold miss, then sequential hits through the line
    do_fetch(32'h0000_0004, 0, 3);
    for (int a = 8; a <= 28; a += 4) do_fetch(32'(a), 0, 0);
    // Conflict eviction on index 0
    do_fetch(32'h0000_0000, 0, 0);
    do_fetch(32'h0000_0400, 0, 0);
    do_fetch(32'h0000_0000, 0, 0);
    // Invalidate in IDLE, then invalidate during a miss
    do_idle(32'h0, 1'b1, 1'b0);
    do_fetch(32'h0000_0004, 0, 2);
    do_fetch(32'h0000_0020, 2, 2);
    do_fetch(32'h0000_0024, 0, 0);
    // Reset mid-miss with a late ack
    do_reset_mid(32'h0000_0040);
    do_fetch(32'h0000_0044, 0, 1);
    // Fetch disabled with a missing pc
    do_idle(32'h0000_0C00, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 60)      do_fetch(rand_pc(), 0, 0);
      else if (r < 70) do_fetch(rand_pc(), 1, 0);
      else if (r < 78) do_fetch(rand_pc(), 2, 0);
      else if (r < 95) do_idle(rand_pc(), ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
      else             do_reset_mid(rand_pc());
    end

    do_idle(32'h0, 1'b0, 1'b0);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("req_queue_drained", 32'(req_addr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
